stream_packet_arbiter: RTL and testbench
========================================

STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

Interface
REQ-001 Parameter DATA_BYTES, default 8, bytes per stream beat; EW = $clog2(DATA_BYTES).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 stream_in0_data/_empty/_valid/_startofpacket/_endofpacket  input  DATA_BYTES*8/EW/1/1/1  Avalon-ST requester 0.
REQ-005 stream_in0_ready  output  1  requester 0 backpressure.
REQ-006 stream_in1_data/_empty/_valid/_startofpacket/_endofpacket  input  DATA_BYTES*8/EW/1/1/1  requester 1, same format.
REQ-007 stream_in1_ready  output  1  requester 1 backpressure.
REQ-008 stream_out_data/_empty/_valid/_startofpacket/_endofpacket  output  DATA_BYTES*8/EW/1/1/1  merged stream toward the endian swapper.
REQ-009 stream_out_ready  input  1  downstream backpressure.
REQ-010 csr_address  input  2  register select.
REQ-011 csr_read, csr_write  input  1  access strobes.
REQ-012 csr_writedata  input  32  write data.
REQ-013 csr_readdata  output  32  read data.
REQ-014 csr_readdatavalid  output  1  read-data qualifier.
REQ-015 csr_waitrequest  output  1  held 0 (accesses never stall).

Function
REQ-016 States: IDLE, GRANT0, GRANT1, with a 1-bit round-robin pointer last_grant.
REQ-017 IDLE: candidate i = in_i valid & startofpacket & CTRL.en[i]; if both are candidates, the input != last_grant wins; the winner's state is entered next cycle, with no beat transferred in the IDLE cycle.
REQ-018 GRANTi: out_* = in_i_* combinationally; in_i_ready = stream_out_ready; the other input's ready = 0.
REQ-019 A beat transfers when out_valid & stream_out_ready.
REQ-020 A transfer with endofpacket in GRANTi SHALL return to IDLE and set last_grant = i; a single-beat packet (sop & eop) grants and releases this way.
REQ-021 Outside GRANT states: stream_out_valid = 0 and the out_* data/flag outputs = 0.
REQ-022 IDLE stray beat (valid & !startofpacket on an enabled input): ready = 1 for that cycle, beat discarded, DROP_CNT incremented; both inputs may drop in the same cycle (+2).
REQ-023 A disabled input SHALL have ready = 0 in IDLE and SHALL never be granted.
REQ-024 Clearing CTRL.en[i] during GRANTi SHALL NOT abort the packet in progress.
REQ-025 A start-of-packet beat seen inside GRANTi is forwarded unchanged; no re-arbitration until endofpacket.
REQ-026 Registers: addr0 CTRL[1:0] en (R/W, others read 0); addr1 PKT_CNT0; addr2 PKT_CNT1; addr3 DROP_CNT.
REQ-027 PKT_CNTi, 32-bit, +1 per endofpacket transfer from input i, wraps 0xFFFFFFFF -> 0.
REQ-028 DROP_CNT, 32-bit, same wrap rule.
REQ-029 A write to addr1-3 clears that counter; a clear in the same cycle as an increment leaves the counter at 0.
REQ-030 Read: csr_readdata registered, csr_readdatavalid = 1 exactly one cycle after csr_read; a same-cycle increment is not visible (pre-increment value returned).
REQ-031 Simultaneous csr_read and csr_write to the same address: read returns the old value and the write takes effect.

Reset
REQ-032 While reset_n = 0 at a clock edge: state = IDLE, last_grant = 1 (input 0 preferred first), CTRL.en = 2'b11, all counters = 0, csr_readdata = 0, csr_readdatavalid = 0.
REQ-033 While reset_n = 0, both in_ready = 0 and stream_out_valid = 0.
REQ-034 Reset mid-packet SHALL abandon the grant; no partial-packet recovery.

Structure
REQ-035 A shared package SHALL hold the state enum, CSR address constants, and the CTRL reset value.
REQ-036 One sub-module, stream_arb_csr, SHALL hold the register file and counters; the FSM and mux stay in the top module.

Verification
REQ-037 Both inputs send 3-beat packets back-to-back -> output alternates in0, in1, in0, in1; PKT_CNT0 = PKT_CNT1 = 2 after 4 packets.
REQ-038 in0 packet with stream_out_ready toggling every cycle -> all beats delivered intact, in1_ready stays 0 until eop accepted.
REQ-039 Stray beat (no sop) on in1 in IDLE -> in1_ready = 1 one cycle, no output beat, DROP_CNT = 1.
REQ-040 CTRL = 2'b01, in1 valid with sop -> in1 never granted, in1_ready = 0; set CTRL = 2'b11 -> in1 granted.
REQ-041 Force PKT_CNT0 to 0xFFFFFFFF, then one in0 packet -> read addr1 returns 0, readdatavalid one cycle after read.
REQ-042 reset_n = 0 mid-packet in GRANT1 -> next cycle IDLE, out_valid = 0, counters 0; in0 is granted first on simultaneous requests.

Source files
------------

// File: rtl/stream_packet_arbiter_pkg.sv
// Shared types and constants for the two-input Avalon-ST packet arbiter.
package stream_packet_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] CSR_CTRL     = 2'd0;
    localparam logic [1:0] CSR_PKT_CNT0 = 2'd1;
    localparam logic [1:0] CSR_PKT_CNT1 = 2'd2;
    localparam logic [1:0] CSR_DROP_CNT = 2'd3;

    // Both inputs enabled out of reset.
    localparam logic [1:0] CTRL_EN_RESET = 2'b11;

endpackage

// File: rtl/stream_arb_csr.sv
// Control/status registers: input enables, per-input packet counters and
// the stray-beat drop counter. Reads are registered with a one-cycle valid.
module stream_arb_csr
    import stream_packet_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        csr_readdatavalid,
    input  logic        pkt_inc0,
    input  logic        pkt_inc1,
    input  logic [1:0]  drop_inc,
    output logic [1:0]  en
);

    logic [31:0] pkt_cnt0;
    logic [31:0] pkt_cnt1;
    logic [31:0] drop_cnt;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    // Only the enable bits of CTRL are writable.
    assign unused_wdata = ^csr_writedata[31:2];

    // CTRL enables.
    always_ff @(posedge clk) begin
        if (!reset_n)                                  en <= CTRL_EN_RESET;
        else if (csr_write && csr_address == CSR_CTRL) en <= csr_writedata[1:0];
    end

    // Packet counter for input 0; a clearing write beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset_n)                                      pkt_cnt0 <= '0;
        else if (csr_write && csr_address == CSR_PKT_CNT0) pkt_cnt0 <= '0;
        else if (pkt_inc0)                                 pkt_cnt0 <= pkt_cnt0 + 32'd1;
    end

    // Packet counter for input 1.
    always_ff @(posedge clk) begin
        if (!reset_n)                                      pkt_cnt1 <= '0;
        else if (csr_write && csr_address == CSR_PKT_CNT1) pkt_cnt1 <= '0;
        else if (pkt_inc1)                                 pkt_cnt1 <= pkt_cnt1 + 32'd1;
    end

    // Drop counter; both inputs may discard a stray beat in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n)                                      drop_cnt <= '0;
        else if (csr_write && csr_address == CSR_DROP_CNT) drop_cnt <= '0;
        else if (drop_inc != 2'd0)                         drop_cnt <= drop_cnt + {30'd0, drop_inc};
    end

    // Read mux over current (pre-update) register values.
    always_comb begin
        rd_mux = '0;
        case (csr_address)
            CSR_CTRL:     rd_mux = {30'd0, en};
            CSR_PKT_CNT0: rd_mux = pkt_cnt0;
            CSR_PKT_CNT1: rd_mux = pkt_cnt1;
            default:      rd_mux = drop_cnt;
        endcase
    end

    // Registered read data, valid exactly one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
        end else begin
            csr_readdatavalid <= csr_read;
            if (csr_read) csr_readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Two-input packet-granular round-robin arbiter merging Avalon-ST streams.
// A grant is held from startofpacket until the endofpacket beat transfers.
module stream_packet_arbiter
    import stream_packet_arbiter_pkg::*;
#(
    parameter  int DATA_BYTES = 8,
    localparam int EW         = $clog2(DATA_BYTES)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_BYTES*8-1:0] stream_in0_data,
    input  logic [EW-1:0]           stream_in0_empty,
    input  logic                    stream_in0_valid,
    input  logic                    stream_in0_startofpacket,
    input  logic                    stream_in0_endofpacket,
    output logic                    stream_in0_ready,
    input  logic [DATA_BYTES*8-1:0] stream_in1_data,
    input  logic [EW-1:0]           stream_in1_empty,
    input  logic                    stream_in1_valid,
    input  logic                    stream_in1_startofpacket,
    input  logic                    stream_in1_endofpacket,
    output logic                    stream_in1_ready,
    output logic [DATA_BYTES*8-1:0] stream_out_data,
    output logic [EW-1:0]           stream_out_empty,
    output logic                    stream_out_valid,
    output logic                    stream_out_startofpacket,
    output logic                    stream_out_endofpacket,
    input  logic                    stream_out_ready,
    input  logic [1:0]              csr_address,
    input  logic                    csr_read,
    input  logic                    csr_write,
    input  logic [31:0]             csr_writedata,
    output logic [31:0]             csr_readdata,
    output logic                    csr_readdatavalid,
    output logic                    csr_waitrequest
);

    arb_state_e state;
    logic       last_grant;
    logic [1:0] en;
    logic       cand0, cand1;
    logic       stray0, stray1;
    logic       pkt_inc0, pkt_inc1;
    logic [1:0] drop_inc;

    assign csr_waitrequest = 1'b0;

    // Arbitration candidates and stray (no-sop) beats are only meaningful in IDLE.
    assign cand0  = (state == ST_IDLE) && stream_in0_valid &&  stream_in0_startofpacket && en[0];
    assign cand1  = (state == ST_IDLE) && stream_in1_valid &&  stream_in1_startofpacket && en[1];
    assign stray0 = (state == ST_IDLE) && stream_in0_valid && !stream_in0_startofpacket && en[0];
    assign stray1 = (state == ST_IDLE) && stream_in1_valid && !stream_in1_startofpacket && en[1];

    assign pkt_inc0 = (state == ST_GRANT0) && stream_in0_valid && stream_out_ready && stream_in0_endofpacket;
    assign pkt_inc1 = (state == ST_GRANT1) && stream_in1_valid && stream_out_ready && stream_in1_endofpacket;
    assign drop_inc = {1'b0, stray0} + {1'b0, stray1};

    // Arbitration FSM; the enable bits only gate new grants, never an open packet.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cand0 && (!cand1 || last_grant)) state <= ST_GRANT0;
                    else if (cand1)                      state <= ST_GRANT1;
                end
                ST_GRANT0: begin
                    if (pkt_inc0) begin
                        state      <= ST_IDLE;
                        last_grant <= 1'b0;
                    end
                end
                ST_GRANT1: begin
                    if (pkt_inc1) begin
                        state      <= ST_IDLE;
                        last_grant <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output mux and backpressure; everything is held quiet while in reset.
    always_comb begin
        stream_out_data          = '0;
        stream_out_empty         = '0;
        stream_out_valid         = 1'b0;
        stream_out_startofpacket = 1'b0;
        stream_out_endofpacket   = 1'b0;
        stream_in0_ready         = 1'b0;
        stream_in1_ready         = 1'b0;
        if (reset_n) begin
            case (state)
                ST_GRANT0: begin
                    stream_out_data          = stream_in0_data;
                    stream_out_empty         = stream_in0_empty;
                    stream_out_valid         = stream_in0_valid;
                    stream_out_startofpacket = stream_in0_startofpacket;
                    stream_out_endofpacket   = stream_in0_endofpacket;
                    stream_in0_ready         = stream_out_ready;
                end
                ST_GRANT1: begin
                    stream_out_data          = stream_in1_data;
                    stream_out_empty         = stream_in1_empty;
                    stream_out_valid         = stream_in1_valid;
                    stream_out_startofpacket = stream_in1_startofpacket;
                    stream_out_endofpacket   = stream_in1_endofpacket;
                    stream_in1_ready         = stream_out_ready;
                end
                default: begin
                    // Stray beats are accepted and thrown away.
                    stream_in0_ready = stray0;
                    stream_in1_ready = stray1;
                end
            endcase
        end
    end

    stream_arb_csr u_csr (
        .clk               (clk),
        .reset_n           (reset_n),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .pkt_inc0          (pkt_inc0),
        .pkt_inc1          (pkt_inc1),
        .drop_inc          (drop_inc),
        .en                (en)
    );

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Scoreboard bench for stream_packet_arbiter: packets are generated per input,
// a packet-level round-robin model decides output order, a monitor checks beats.
module tb_stream_packet_arbiter;

    localparam int DB  = 8;
    localparam int DW  = DB * 8;
    localparam int EW  = $clog2(DB);
    localparam int TMO = 200;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_data  [2];
    logic [EW-1:0] in_empty [2];
    logic          in_valid [2];
    logic          in_sop   [2];
    logic          in_eop   [2];
    logic          in_ready0, in_ready1;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_empty;
    logic          out_valid, out_sop, out_eop;
    logic          out_ready = 1'b1;
    logic [1:0]    csr_address = '0;
    logic          csr_read = 1'b0, csr_write = 1'b0;
    logic [31:0]   csr_writedata = '0;
    logic [31:0]   csr_readdata;
    logic          csr_readdatavalid, csr_waitrequest;

    int    n_chk = 0, n_pass = 0;
    int    rdy_mode = 3;
    bit    m_last = 1'b1;
    bit    done0;
    beat_t sb[$];
    beat_t txq0[$], txq1[$];
    int    len0[$], len1[$];
    beat_t mon_e;

    stream_packet_arbiter #(.DATA_BYTES(DB)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .stream_in0_data          (in_data[0]),
        .stream_in0_empty         (in_empty[0]),
        .stream_in0_valid         (in_valid[0]),
        .stream_in0_startofpacket (in_sop[0]),
        .stream_in0_endofpacket   (in_eop[0]),
        .stream_in0_ready         (in_ready0),
        .stream_in1_data          (in_data[1]),
        .stream_in1_empty         (in_empty[1]),
        .stream_in1_valid         (in_valid[1]),
        .stream_in1_startofpacket (in_sop[1]),
        .stream_in1_endofpacket   (in_eop[1]),
        .stream_in1_ready         (in_ready1),
        .stream_out_data          (out_data),
        .stream_out_empty         (out_empty),
        .stream_out_valid         (out_valid),
        .stream_out_startofpacket (out_sop),
        .stream_out_endofpacket   (out_eop),
        .stream_out_ready         (out_ready),
        .csr_address              (csr_address),
        .csr_read                 (csr_read),
        .csr_write                (csr_write),
        .csr_writedata            (csr_writedata),
        .csr_readdata             (csr_readdata),
        .csr_readdatavalid        (csr_readdatavalid),
        .csr_waitrequest          (csr_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got timeout/unexpected expected handshake", name);
    endtask

    // Downstream ready pattern: 0 random, 1 toggle, 2 stalled, 3 always ready.
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = !out_ready;
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: every accepted output beat must be the next scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) fail_now("unexpected_beat");
            else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_flags", {out_empty, out_sop, out_eop}, {mon_e.empty, mon_e.sop, mon_e.eop});
            end
        end
    end

    task automatic make_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = {$urandom, $urandom};
            b.empty = (i == len - 1) ? EW'($urandom) : '0;
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            if (p == 0) txq0.push_back(b); else txq1.push_back(b);
        end
        if (p == 0) len0.push_back(len); else len1.push_back(len);
    endtask

    // Packet-level model: inputs keep their next sop presented, so whenever both
    // have a packet left the one not served last wins.
    task automatic model_order();
        int i0 = 0, i1 = 0, p, len;
        while (len0.size() > 0 || len1.size() > 0) begin
            if (len0.size() > 0 && len1.size() > 0) p = m_last ? 0 : 1;
            else p = (len0.size() > 0) ? 0 : 1;
            len = (p == 0) ? len0.pop_front() : len1.pop_front();
            for (int k = 0; k < len; k++) sb.push_back((p == 0) ? txq0[i0 + k] : txq1[i1 + k]);
            if (p == 0) i0 += len; else i1 += len;
            m_last = (p == 1);
        end
    endtask

    task automatic drive(input int p, input bit gaps);
        beat_t b;
        bit    acc;
        int    n;
        while ((p == 0) ? (txq0.size() > 0) : (txq1.size() > 0)) begin
            b = (p == 0) ? txq0.pop_front() : txq1.pop_front();
            if (gaps && !b.sop && $urandom_range(0, 2) == 0) begin
                in_valid[p] = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_data[p] = b.data; in_empty[p] = b.empty;
            in_sop[p] = b.sop; in_eop[p] = b.eop; in_valid[p] = 1'b1;
            acc = 1'b0; n = 0;
            while (!acc && n < TMO) begin
                @(negedge clk);
                acc = (p == 0) ? in_ready0 : in_ready1;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) fail_now("drive_accept");
        end
        in_valid[p] = 1'b0; in_sop[p] = 1'b0; in_eop[p] = 1'b0;
    endtask

    task automatic run_traffic(input bit gaps);
        model_order();
        fork
            drive(0, gaps);
            drive(1, gaps);
        join
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        csr_address = a; csr_read = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0;
        @(negedge clk);
        check({name, "_rdv"}, csr_readdatavalid, 1'b1);
        check(name, csr_readdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic stray(input bit s0, input bit s1);
        in_sop[0] = 1'b0; in_sop[1] = 1'b0;
        in_valid[0] = s0; in_valid[1] = s1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        for (int i = 0; i < 2; i++) begin
            in_data[i] = '0; in_empty[i] = '0; in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
        end
        // Reset with a stray beat present: ready must still be held low.
        in_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in0_ready", in_ready0, 1'b0);
        check("rst_in1_ready", in_ready1, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_rdv", csr_readdatavalid, 1'b0);
        check("rst_rdata", csr_readdata, 32'd0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        csr_rd(2'd0, 32'd3, "rst_ctrl");
        csr_rd(2'd1, 32'd0, "rst_pkt0");

        // Stray beat on in1 in IDLE.
        in_valid[1] = 1'b1; in_sop[1] = 1'b0;
        @(negedge clk);
        check("stray_in1_ready", in_ready1, 1'b1);
        check("stray_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(negedge clk);
        check("stray_after_ready", in_ready1, 1'b0);
        @(posedge clk); #1;
        csr_rd(2'd3, 32'd1, "drop_1");
        stray(1'b1, 1'b1);
        csr_rd(2'd3, 32'd3, "drop_3");
        // Clear collides with an increment: counter ends at zero.
        csr_address = 2'd3; csr_writedata = '0; csr_write = 1'b1;
        stray(1'b1, 1'b0);
        csr_write = 1'b0;
        csr_rd(2'd3, 32'd0, "drop_clr_collide");
        // Simultaneous read and write: old value read, then cleared.
        stray(1'b0, 1'b1);
        csr_address = 2'd3; csr_read = 1'b1; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0; csr_write = 1'b0;
        @(negedge clk);
        check("rw_same_rdv", csr_readdatavalid, 1'b1);
        check("rw_same_old", csr_readdata, 32'd1);
        @(posedge clk); #1;
        csr_rd(2'd3, 32'd0, "rw_same_new");

        // Back-to-back 3-beat packets on both inputs alternate.
        rdy_mode = 3;
        for (int i = 0; i < 2; i++) begin make_pkt(0, 3); make_pkt(1, 3); end
        run_traffic(1'b0);
        csr_rd(2'd1, 32'd2, "alt_pkt0");
        csr_rd(2'd2, 32'd2, "alt_pkt1");

        // Toggling downstream ready; in1 must wait for in0's eop.
        rdy_mode = 1;
        make_pkt(0, 4); make_pkt(1, 2);
        model_order();
        done0 = 1'b0;
        fork
            begin drive(0, 1'b0); done0 = 1'b1; end
            drive(1, 1'b0);
            begin
                while (!done0) begin
                    @(negedge clk);
                    if (!done0) check("tog_in1_ready", in_ready1, 1'b0);
                end
            end
        join
        check("tog_sb_drained", sb.size(), 0);

        // Disabled input is never granted until re-enabled.
        rdy_mode = 3;
        csr_wr(2'd0, 32'h1);
        csr_rd(2'd0, 32'h1, "ctrl_01");
        make_pkt(1, 2);
        model_order();
        fork
            drive(1, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("dis_in1_ready", in_ready1, 1'b0);
                    check("dis_out_valid", out_valid, 1'b0);
                end
                csr_wr(2'd0, 32'h3);
            end
        join
        check("dis_sb_drained", sb.size(), 0);

        // Counter wrap, with read-valid timing around the read strobe.
        force dut.u_csr.pkt_cnt0 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.u_csr.pkt_cnt0;
        make_pkt(0, 1);
        run_traffic(1'b0);
        csr_address = 2'd1; csr_read = 1'b1;
        @(negedge clk);
        check("wrap_rdv_early", csr_readdatavalid, 1'b0);
        @(posedge clk); #1;
        csr_read = 1'b0;
        @(negedge clk);
        check("wrap_rdv", csr_readdatavalid, 1'b1);
        check("wrap_pkt0", csr_readdata, 32'd0);
        @(negedge clk);
        check("wrap_rdv_late", csr_readdatavalid, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic with random gaps and random downstream ready.
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd2, 32'd0);
        rdy_mode = 0;
        c0 = $urandom_range(3, 8); c1 = $urandom_range(3, 8);
        for (int i = 0; i < c0; i++) make_pkt(0, $urandom_range(1, 6));
        for (int i = 0; i < c1; i++) make_pkt(1, $urandom_range(1, 6));
        run_traffic(1'b1);
        rdy_mode = 3;
        @(posedge clk); #1;
        csr_rd(2'd1, 32'(c0), "rnd_pkt0");
        csr_rd(2'd2, 32'(c1), "rnd_pkt1");

        // Reset in the middle of a GRANT1 packet.
        rdy_mode = 2;
        @(posedge clk); #1;
        in_data[1] = {$urandom, $urandom}; in_sop[1] = 1'b1; in_eop[1] = 1'b0; in_valid[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("g1_out_valid", out_valid, 1'b1);
        check("g1_out_data", out_data, in_data[1]);
        @(posedge clk); #1;
        reset_n = 1'b0;
        in_valid[0] = 1'b1; in_sop[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_in0_ready", in_ready0, 1'b0);
        check("mid_rst_in1_ready", in_ready1, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_last = 1'b1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0; in_sop[1] = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        rdy_mode = 3;
        csr_rd(2'd1, 32'd0, "post_rst_pkt0");
        csr_rd(2'd2, 32'd0, "post_rst_pkt1");
        make_pkt(0, 1); make_pkt(1, 1);
        run_traffic(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
